// File: rtl/clkdiv_prog.sv
// clkdiv_prog -- multi-channel programmable clock divider.
//
// Each channel counts enabled cycles up to its current half-period divisor
// (div_cur) and then toggles its divided clock and pulses a one-cycle tick.
// Divisors are changed at run time through a registered write handshake.
// A new divisor is held pending and applied only at the channel's next
// terminal count, so a half-period already in progress is never altered.
//
// Optional feature: define CLKDIV_SYNC_EN to add the sync_i port. A sync
// pulse re-phases every channel (counter and divided clock to 0) and loads
// any pending divisor immediately.
//
// Ports:
//   clk_i       system clock, all logic on posedge
//   rst_n_i     synchronous reset, active low
//   en_i        per-channel count enable
//   div_wr_i    divisor write request (single cycle)
//   div_sel_i   target channel of the write
//   div_data_i  new half-period divisor
//   sync_i      (CLKDIV_SYNC_EN only) re-phase all channels
//   div_ack_o   write accepted, 1-cycle pulse
//   div_err_o   write rejected (zero divisor or channel out of range)
//   clk_div_o   divided clocks, period = 2*div_cur enabled cycles
//   tick_o      1-cycle strobe coincident with each clk_div_o toggle
module clkdiv_prog #(
  parameter int NCH         = 4,
  parameter int CW          = 32,
  parameter int DEFAULT_DIV = 31250,
  localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NCH-1:0]   en_i,
  input  logic             div_wr_i,
  input  logic [SELW-1:0]  div_sel_i,
  input  logic [CW-1:0]    div_data_i,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             div_ack_o,
  output logic             div_err_o,
  output logic [NCH-1:0]   clk_div_o,
  output logic [NCH-1:0]   tick_o
);

  localparam logic [CW-1:0] DEF_DIV = CW'(DEFAULT_DIV);

  logic sync_w;
`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // When NCH fills the select field every encoding is a valid channel;
  // the range test only exists when some encodings are unused.
  logic sel_ok;
  generate
    if (NCH < (1 << SELW)) begin : g_selchk
      assign sel_ok = (div_sel_i < SELW'(NCH));
    end else begin : g_selall
      assign sel_ok = 1'b1;
    end
  endgenerate

  logic wr_ok;
  assign wr_ok = div_wr_i && (div_data_i != '0) && sel_ok;

  logic ack_q, err_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= wr_ok;
      err_q <= div_wr_i && !wr_ok;
    end
  end
  assign div_ack_o = ack_q;
  assign div_err_o = err_q;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] cur_q, cur_d;
      logic [CW-1:0] nxt_q, nxt_d;
      logic          pend_q, pend_d;
      logic          clk_q, clk_d;
      logic          tick_q, tick_d;
      logic          term;

      assign term = (cnt_q == cur_q - CW'(1));

      always_comb begin
        cnt_d  = cnt_q;
        cur_d  = cur_q;
        nxt_d  = nxt_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (sync_w) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (pend_q) begin
            cur_d  = nxt_q;
            pend_d = 1'b0;
          end
        end else if (en_i[i]) begin
          if (term) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
            // Boundary uses the pre-cycle pending value; a write in this
            // same cycle lands below and waits for the next boundary.
            if (pend_q) begin
              cur_d  = nxt_q;
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        if (wr_ok && (div_sel_i == SELW'(i))) begin
          nxt_d  = div_data_i;
          pend_d = 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          cnt_q  <= '0;
          cur_q  <= DEF_DIV;
          nxt_q  <= '0;
          pend_q <= 1'b0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          cur_q  <= cur_d;
          nxt_q  <= nxt_d;
          pend_q <= pend_d;
          clk_q  <= clk_d;
          tick_q <= tick_d;
        end
      end

      assign clk_div_o[i] = clk_q;
      assign tick_o[i]    = tick_q;
    end
  endgenerate

endmodule

// File: tb/tb_clkdiv_prog.sv
module tb_clkdiv_prog;
  localparam int NCH  = 5;
  localparam int CW   = 16;
  localparam int DEF  = 4;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            div_wr;
  logic [SELW-1:0] div_sel;
  logic [CW-1:0]   div_data;
`ifdef CLKDIV_SYNC_EN
  logic            sync;
`endif
  logic            div_ack, div_err;
  logic [NCH-1:0]  clk_div, tick;

  clkdiv_prog #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEF)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .div_wr_i(div_wr),
    .div_sel_i(div_sel), .div_data_i(div_data),
`ifdef CLKDIV_SYNC_EN
    .sync_i(sync),
`endif
    .div_ack_o(div_ack), .div_err_o(div_err),
    .clk_div_o(clk_div), .tick_o(tick)
  );

  initial forever #5 clk = ~clk;

  // Reference model: remaining enabled cycles before the next toggle.
  int             rem [NCH];
  int             cur [NCH];
  int             nxt [NCH];
  bit             pend[NCH];
  logic [NCH-1:0] m_clk, m_tick;
  logic           m_ack, m_err;
  int             n_total = 0;
  int             n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      rem[i] = DEF; cur[i] = DEF; nxt[i] = 0; pend[i] = 0;
    end
    m_clk = '0; m_tick = '0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ok, do_sync;
    do_sync = 0;
`ifdef CLKDIV_SYNC_EN
    do_sync = sync;
`endif
    if (!rst_n) begin
      model_reset();
      return;
    end
    ok = div_wr && (div_data != 0) && (int'(div_sel) < NCH);
    m_ack = ok;
    m_err = div_wr && !ok;
    m_tick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (do_sync) begin
        if (pend[i]) begin cur[i] = nxt[i]; pend[i] = 0; end
        rem[i] = cur[i];
        m_clk[i] = 1'b0;
      end else if (en[i]) begin
        rem[i]--;
        if (rem[i] == 0) begin
          m_clk[i]  = ~m_clk[i];
          m_tick[i] = 1'b1;
          if (pend[i]) begin cur[i] = nxt[i]; pend[i] = 0; end
          rem[i] = cur[i];
        end
      end
    end
    if (ok) begin
      nxt[div_sel] = div_data;
      pend[div_sel] = 1;
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".clk_div"}, 32'(clk_div), 32'(m_clk));
    chk({tag, ".tick"},    32'(tick),    32'(m_tick));
    chk({tag, ".ack"},     32'(div_ack), 32'(m_ack));
    chk({tag, ".err"},     32'(div_err), 32'(m_err));
    div_wr = 1'b0;
  endtask

  task automatic write(input int sel, input int data);
    div_wr = 1'b1; div_sel = SELW'(sel); div_data = CW'(data);
  endtask

  initial begin
    rst_n = 1'b0; en = '0; div_wr = 1'b0; div_sel = '0; div_data = '0;
`ifdef CLKDIV_SYNC_EN
    sync = 1'b0;
`endif
    model_reset();
    m_clk = 'x;
    repeat (2) step("reset");
    chk("reset.clk0", 32'(clk_div), 32'h0);
    chk("reset.tick0", 32'(tick), 32'h0);

    // First rising edge DEF enabled cycles after release, period 2*DEF.
    rst_n = 1'b1; en = '1;
    for (int c = 1; c <= 3; c++) begin
      step("t1.pre");
      chk("t1.low", 32'(clk_div), 32'h0);
    end
    step("t1.edge");
    chk("t1.rise", 32'(clk_div), 32'h1F);
    chk("t1.tick", 32'(tick), 32'h1F);
    repeat (4) step("t1.run");
    chk("t1.fall", 32'(clk_div), 32'h00);

    // Hold ch1 for 3 cycles at cnt=2.
    repeat (2) step("t2.pre");
    en = 5'b11101;
    repeat (3) step("t2.hold");
    en = '1;
    repeat (6) step("t2.run");

    // Write divisor 2 to ch2 at cnt=1.
    while (1) begin
      step("t3.align");
      if (tick[0]) break;
      if (n_total > 2000) begin chk("t3.timeout", 1, 0); break; end
    end
    step("t3.cnt1");
    write(2, 2);
    step("t3.wr");
    chk("t3.ack", 32'(div_ack), 32'h1);
    repeat (8) step("t3.run");

    // Rejected writes: zero divisor, channel out of range.
    write(1, 0);
    step("t4.zero");
    chk("t4.err0", 32'(div_err), 32'h1);
    write(5, 3);
    step("t4.sel5");
    chk("t4.err5", 32'(div_err), 32'h1);
    chk("t4.noack", 32'(div_ack), 32'h0);
    // Write landing on a ch0 terminal count.
    while (!(rem[0] == 1)) step("t4.align");
    write(0, 3);
    step("t4.tc");
    repeat (12) step("t4.run");

    // Reset mid-count with a write pending.
    write(3, 7);
    step("t5.wr");
    rst_n = 1'b0;
    step("t5.rst");
    chk("t5.clk0", 32'(clk_div), 32'h0);
    rst_n = 1'b1;
    repeat (12) step("t5.run");

`ifdef CLKDIV_SYNC_EN
    write(0, 3); step("t6.w0");
    write(1, 5); step("t6.w1");
    repeat (23) step("t6.drift");
    sync = 1'b1;
    step("t6.sync");
    sync = 1'b0;
    chk("t6.synclow", 32'(clk_div), 32'h0);
    repeat (12) step("t6.run");
`endif

    // Randomized phase against the model.
    for (int c = 0; c < 600; c++) begin
      en = NCH'($urandom | $urandom);
      if ($urandom_range(0, 3) == 0) write($urandom_range(0, 7), $urandom_range(0, 6));
      rst_n = ($urandom_range(0, 199) != 0);
`ifdef CLKDIV_SYNC_EN
      sync = ($urandom_range(0, 99) == 0);
`endif
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
